// File: rtl/cpu_params_pkg.sv
// Shared constants for the EIO responder: register offsets, ID value and FSM state type.
package cpu_params_pkg;

    localparam logic [5:0] EIO_OFF_ID         = 6'h00;
    localparam logic [5:0] EIO_OFF_SCRATCH    = 6'h04;
    localparam logic [5:0] EIO_OFF_GPIO_OUT   = 6'h08;
    localparam logic [5:0] EIO_OFF_GPIO_IN    = 6'h0C;
    localparam logic [5:0] EIO_OFF_TIMER_LO   = 6'h10;
    localparam logic [5:0] EIO_OFF_TIMER_HI   = 6'h14;
    localparam logic [5:0] EIO_OFF_TIMECMP_LO = 6'h18;
    localparam logic [5:0] EIO_OFF_TIMECMP_HI = 6'h1C;

    localparam logic [31:0] EIO_ID_VALUE = 32'h524B_3100;

    typedef enum logic [1:0] {
        EIO_IDLE,
        EIO_WAIT,
        EIO_ACK
    } EIO_RESP_STATE;

endpackage

// File: rtl/eio_timer.sv
// Free-running 64-bit timer with HI shadow latch, TIMECMP registers and registered compare IRQ.
module eio_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        lo_rd,
    input  logic        cmp_lo_wr,
    input  logic        cmp_hi_wr,
    input  logic [31:0] wr_data,
    output logic [31:0] timer_lo,
    output logic [31:0] shadow,
    output logic [63:0] timecmp,
    output logic        irq
);
    logic [63:0] timer;

    // Shadow captures the upper half in the same cycle the lower half is returned.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer   <= '0;
            shadow  <= '0;
            timecmp <= '1;
            irq     <= 1'b0;
        end else begin
            timer <= timer + 64'd1;
            irq   <= (timer >= timecmp);
            if (lo_rd)
                shadow <= timer[63:32];
            if (cmp_lo_wr)
                timecmp[31:0] <= wr_data;
            if (cmp_hi_wr)
                timecmp[63:32] <= wr_data;
        end
    end

    assign timer_lo = timer[31:0];

endmodule

// File: rtl/eio_responder.sv
// EIO bus slave: windowed word decode, programmable wait states, ID/scratch/GPIO registers.
// Optional timer with compare interrupt is built when EIO_TIMER_EN is defined.
module eio_responder
    import cpu_params_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
    parameter int          WAIT_CYCLES = 0,
    parameter int          GPIO_W      = 8
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              eio_req_in,
    input  logic              eio_rd_in,
    input  logic              eio_wr_in,
    input  logic [31:0]       eio_addr_in,
    input  logic [31:0]       eio_wr_data_in,
    output logic              eio_ack_out,
    output logic              eio_ack_fault_out,
    output logic [31:0]       eio_ack_data_out,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq_out
);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    EIO_RESP_STATE     state, state_next;
    logic [3:0]        wait_cnt;
    logic [5:0]        offset_q;
    logic              rd_q, wr_q, fault_q;
    logic [31:0]       wr_data_q;
    logic [31:0]       scratch;
    logic [GPIO_W-1:0] gpio_sync1, gpio_sync2;
    logic [5:0]        dec_offset;
    logic              dec_mapped, dec_ro, dec_fault;
    logic              do_write;
    logic [31:0]       read_data;

    // Decode straight off the bus so the fault decision is ready at the sampling edge.
    always_comb begin
        dec_offset = eio_addr_in[5:0];
`ifdef EIO_TIMER_EN
        dec_mapped = (dec_offset <= EIO_OFF_TIMECMP_HI);
`else
        dec_mapped = (dec_offset <= EIO_OFF_GPIO_IN);
`endif
        dec_ro = (dec_offset == EIO_OFF_ID) || (dec_offset == EIO_OFF_GPIO_IN) ||
                 (dec_offset == EIO_OFF_TIMER_LO) || (dec_offset == EIO_OFF_TIMER_HI);
        dec_fault = (eio_addr_in[31:6] != BASE_ADDR[31:6]) || (eio_addr_in[1:0] != 2'b00) ||
                    !dec_mapped || (eio_rd_in == eio_wr_in) || (eio_wr_in && dec_ro);
    end

    always_ff @(posedge clk_in) begin
        if (reset_in)
            state <= EIO_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            EIO_IDLE:
                if (eio_req_in)
                    state_next = (dec_fault || WAIT_CYCLES == 0) ? EIO_ACK : EIO_WAIT;
            EIO_WAIT:
                if (wait_cnt == 4'd0)
                    state_next = EIO_ACK;
            EIO_ACK:
                state_next = EIO_IDLE;
            default:
                state_next = EIO_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wait_cnt  <= '0;
            offset_q  <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            fault_q   <= 1'b0;
            wr_data_q <= '0;
        end else if (state == EIO_IDLE && eio_req_in) begin
            wait_cnt  <= WAIT_LOAD;
            offset_q  <= dec_offset;
            rd_q      <= eio_rd_in;
            wr_q      <= eio_wr_in;
            fault_q   <= dec_fault;
            wr_data_q <= eio_wr_data_in;
        end else if (state == EIO_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    assign do_write = (state == EIO_ACK) && !fault_q && wr_q;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            scratch    <= '0;
            gpio_out   <= '0;
            gpio_sync1 <= '0;
            gpio_sync2 <= '0;
        end else begin
            gpio_sync1 <= gpio_in;
            gpio_sync2 <= gpio_sync1;
            if (do_write) begin
                case (offset_q)
                    EIO_OFF_SCRATCH:  scratch  <= wr_data_q;
                    EIO_OFF_GPIO_OUT: gpio_out <= wr_data_q[GPIO_W-1:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef EIO_TIMER_EN
    logic [31:0] timer_lo;
    logic [31:0] timer_shadow;
    logic [63:0] timecmp;

    eio_timer u_timer (
        .clk       (clk_in),
        .reset     (reset_in),
        .lo_rd     ((state == EIO_ACK) && !fault_q && rd_q && (offset_q == EIO_OFF_TIMER_LO)),
        .cmp_lo_wr (do_write && (offset_q == EIO_OFF_TIMECMP_LO)),
        .cmp_hi_wr (do_write && (offset_q == EIO_OFF_TIMECMP_HI)),
        .wr_data   (wr_data_q),
        .timer_lo  (timer_lo),
        .shadow    (timer_shadow),
        .timecmp   (timecmp),
        .irq       (timer_irq_out)
    );
`else
    assign timer_irq_out = 1'b0;
`endif

    always_comb begin
        read_data = '0;
        case (offset_q)
            EIO_OFF_ID:         read_data = EIO_ID_VALUE;
            EIO_OFF_SCRATCH:    read_data = scratch;
            EIO_OFF_GPIO_OUT:   read_data[GPIO_W-1:0] = gpio_out;
            EIO_OFF_GPIO_IN:    read_data[GPIO_W-1:0] = gpio_sync2;
`ifdef EIO_TIMER_EN
            EIO_OFF_TIMER_LO:   read_data = timer_lo;
            EIO_OFF_TIMER_HI:   read_data = timer_shadow;
            EIO_OFF_TIMECMP_LO: read_data = timecmp[31:0];
            EIO_OFF_TIMECMP_HI: read_data = timecmp[63:32];
`endif
            default:            read_data = '0;
        endcase
    end

    always_comb begin
        eio_ack_out       = (state == EIO_ACK);
        eio_ack_fault_out = (state == EIO_ACK) && fault_q;
        eio_ack_data_out  = ((state == EIO_ACK) && !fault_q && rd_q) ? read_data : '0;
    end

endmodule

// File: tb/tb_eio_responder.sv
// Self-checking bench for eio_responder (WAIT_CYCLES=3, GPIO_W=8); timer checks follow EIO_TIMER_EN.
module tb_eio_responder;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam int          WAIT = 3;
    localparam logic [31:0] ID   = 32'h524B_3100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        eio_req = 1'b0, eio_rd = 1'b0, eio_wr = 1'b0;
    logic [31:0] eio_addr = '0, eio_wdata = '0;
    logic        eio_ack, eio_fault;
    logic [31:0] eio_data;
    logic [7:0]  gpio_in = '0;
    logic [7:0]  gpio_out;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rst_edge = 0;

    logic [31:0] model_scratch;
    logic [7:0]  model_gpio;
    logic [31:0] model_shadow;
    logic [63:0] model_cmp;

    eio_responder #(
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (WAIT),
        .GPIO_W      (8)
    ) dut (
        .clk_in            (clk),
        .reset_in          (rst),
        .eio_req_in        (eio_req),
        .eio_rd_in         (eio_rd),
        .eio_wr_in         (eio_wr),
        .eio_addr_in       (eio_addr),
        .eio_wr_data_in    (eio_wdata),
        .eio_ack_out       (eio_ack),
        .eio_ack_fault_out (eio_fault),
        .eio_ack_data_out  (eio_data),
        .gpio_in           (gpio_in),
        .gpio_out          (gpio_out),
        .timer_irq_out     (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: register behaviour as a plain map keyed by byte offset from BASE.
    function automatic void model_access(input logic rd, input logic wr, input logic [31:0] addr,
                                         input logic [31:0] wdata, input int ack_cyc,
                                         output logic f, output logic [31:0] d, output int lat);
        logic [31:0] off;
        logic [63:0] tnow;
        off  = addr - BASE;
        tnow = 64'(ack_cyc - rst_edge);
        f = 1'b0;
        d = '0;
        if (rd == wr || off > 32'h3F || (off % 4) != 0) begin
            f = 1'b1;
        end else begin
            case (off)
                32'h00: if (wr) f = 1'b1; else d = ID;
                32'h04: if (wr) model_scratch = wdata; else d = model_scratch;
                32'h08: if (wr) model_gpio = wdata[7:0]; else d = {24'd0, model_gpio};
                32'h0C: if (wr) f = 1'b1; else d = {24'd0, gpio_in};
`ifdef EIO_TIMER_EN
                32'h10: if (wr) f = 1'b1; else begin d = tnow[31:0]; model_shadow = tnow[63:32]; end
                32'h14: if (wr) f = 1'b1; else d = model_shadow;
                32'h18: if (wr) model_cmp[31:0] = wdata; else d = model_cmp[31:0];
                32'h1C: if (wr) model_cmp[63:32] = wdata; else d = model_cmp[63:32];
`endif
                default: f = 1'b1;
            endcase
        end
        lat = f ? 1 : 1 + WAIT;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        eio_req = 1'b0;
        eio_rd = 1'b0;
        eio_wr = 1'b0;
        @(posedge clk); #1;
        rst_edge = cyc;
        rst = 1'b0;
        model_scratch = '0;
        model_gpio    = '0;
        model_shadow  = '0;
        model_cmp     = '1;
    endtask

    // Drives one transaction and waits (bounded) for ack; lat = -1 means no ack arrived.
    task automatic bus_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, output int lat, output logic fault,
                              output logic [31:0] data, output int ack_cyc);
        eio_req = 1'b1;
        eio_rd = rd;
        eio_wr = wr;
        eio_addr = addr;
        eio_wdata = wdata;
        lat = -1;
        fault = 1'b0;
        data = '0;
        ack_cyc = 0;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk); #1;
            if (eio_ack === 1'b1) begin
                lat = i;
                fault = eio_fault;
                data = eio_data;
                ack_cyc = cyc;
                break;
            end
        end
        eio_req = 1'b0;
        eio_rd = 1'b0;
        eio_wr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int lat, ac;
        logic f;
        logic [31:0] d;
        apply_reset();
        checks++;
        if ({eio_ack, eio_fault, eio_data, gpio_out, irq} !== 43'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got ack=%b fault=%b data=%h gpio=%h irq=%b expected all 0",
                     eio_ack, eio_fault, eio_data, gpio_out, irq);
        end
        bus_access(1'b1, 1'b0, BASE + 32'h04, '0, lat, f, d, ac);
        checks++;
        if (d !== 32'd0 || f !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_scratch: got data=%h fault=%b expected 00000000 0", d, f);
        end
`ifdef EIO_TIMER_EN
        bus_access(1'b1, 1'b0, BASE + 32'h14, '0, lat, f, d, ac);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_shadow: got %h expected 00000000", d);
        end
`endif
    endtask

    task automatic test_id_latency();
        int lat, ac;
        logic f;
        logic [31:0] d;
        bus_access(1'b1, 1'b0, BASE, '0, lat, f, d, ac);
        checks++;
        if (lat !== 1 + WAIT || f !== 1'b0 || d !== ID) begin
            errors++;
            $display("[TB] FAIL id_read: got lat=%0d fault=%b data=%h expected lat=%0d fault=0 data=%h",
                     lat, f, d, 1 + WAIT, ID);
        end
    endtask

    task automatic test_scratch_gpio();
        int lat, ac, el;
        logic f, ef;
        logic [31:0] d, ed, v;
        for (int i = 0; i < 4; i++) begin
            v = (i == 0) ? 32'hA5A5_1234 : $urandom;
            bus_access(1'b0, 1'b1, BASE + 32'h04, v, lat, f, d, ac);
            model_access(1'b0, 1'b1, BASE + 32'h04, v, ac, ef, ed, el);
            bus_access(1'b1, 1'b0, BASE + 32'h04, '0, lat, f, d, ac);
            checks++;
            if (d !== v || f !== 1'b0 || lat !== 1 + WAIT) begin
                errors++;
                $display("[TB] FAIL scratch_rw: got data=%h fault=%b lat=%0d expected %h 0 %0d", d, f, lat, v, 1 + WAIT);
            end
        end
        for (int i = 0; i < 3; i++) begin
            v = (i == 0) ? 32'hFFFF_FFFF : $urandom;
            bus_access(1'b0, 1'b1, BASE + 32'h08, v, lat, f, d, ac);
            checks++;
            if (gpio_out !== v[7:0]) begin
                errors++;
                $display("[TB] FAIL gpio_out: got %h expected %h", gpio_out, v[7:0]);
            end
            bus_access(1'b1, 1'b0, BASE + 32'h08, '0, lat, f, d, ac);
            checks++;
            if (d !== {24'd0, v[7:0]}) begin
                errors++;
                $display("[TB] FAIL gpio_readback: got %h expected %h", d, {24'd0, v[7:0]});
            end
        end
        model_gpio = v[7:0];
    endtask

    task automatic test_faults();
        int lat, ac;
        logic f, r, w;
        logic [31:0] d, a, sval;
        sval = $urandom;
        bus_access(1'b0, 1'b1, BASE + 32'h04, sval, lat, f, d, ac);
        model_scratch = sval;
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: begin r = 1'b1; w = 1'b0; a = BASE + 32'h40; end
                1: begin r = 1'b1; w = 1'b0; a = BASE + 32'h06; end
                2: begin r = 1'b0; w = 1'b1; a = BASE; end
                3: begin r = 1'b1; w = 1'b1; a = BASE + 32'h04; end
                4: begin r = 1'b0; w = 1'b0; a = BASE + 32'h04; end
                5: begin r = 1'b1; w = 1'b0; a = BASE + 32'h20; end
                6: begin r = 1'b0; w = 1'b1; a = BASE + 32'h0C; end
                7: begin r = 1'b1; w = 1'b0; a = BASE - 32'h4; end
`ifdef EIO_TIMER_EN
                default: begin r = 1'b0; w = 1'b1; a = BASE + 32'h10; end
`else
                default: begin r = 1'b1; w = 1'b0; a = BASE + 32'h10; end
`endif
            endcase
            bus_access(r, w, a, 32'h1111_0000 + 32'(i), lat, f, d, ac);
            checks++;
            if (lat !== 1 || f !== 1'b1 || d !== 32'd0) begin
                errors++;
                $display("[TB] FAIL fault_%0d: got lat=%0d fault=%b data=%h expected lat=1 fault=1 data=0", i, lat, f, d);
            end
        end
        bus_access(1'b1, 1'b0, BASE + 32'h04, '0, lat, f, d, ac);
        checks++;
        if (d !== sval) begin
            errors++;
            $display("[TB] FAIL fault_no_side_effect: got scratch=%h expected %h", d, sval);
        end
    endtask

    task automatic test_timer();
        int lat, ac, t;
        logic f, ei;
        logic [31:0] d;
`ifdef EIO_TIMER_EN
        int ok;
        logic [63:0] tlo;
        apply_reset();
        bus_access(1'b0, 1'b1, BASE + 32'h1C, 32'd0, lat, f, d, ac);
        bus_access(1'b0, 1'b1, BASE + 32'h18, 32'd100, lat, f, d, ac);
        model_cmp = 64'd100;
        ok = 1;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            t = cyc - rst_edge;
            ei = ((t - 1) >= 100);
            if (irq !== ei && ok == 1) begin
                ok = 0;
                $display("[TB] FAIL timer_irq: at timer=%0d got %b expected %b", t, irq, ei);
            end
        end
        checks++;
        if (ok == 0) errors++;
        bus_access(1'b1, 1'b0, BASE + 32'h10, '0, lat, f, d, ac);
        tlo = 64'(ac - rst_edge);
        checks++;
        if (d !== tlo[31:0] || f !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timer_lo: got %h expected %h", d, tlo[31:0]);
        end
        bus_access(1'b1, 1'b0, BASE + 32'h14, '0, lat, f, d, ac);
        checks++;
        if (d !== tlo[63:32]) begin
            errors++;
            $display("[TB] FAIL timer_hi: got %h expected %h", d, tlo[63:32]);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timer_irq_hold: got %b expected 1", irq);
        end
`else
        bus_access(1'b0, 1'b1, BASE + 32'h18, 32'd0, lat, f, d, ac);
        checks++;
        if (lat !== 1 || f !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timecmp_absent: got lat=%0d fault=%b expected lat=1 fault=1", lat, f);
        end
        t = 0;
        ei = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (irq !== 1'b0) ei = 1'b1;
        end
        checks++;
        if (ei !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_tied: got irq=1 expected 0");
        end
`endif
    endtask

    task automatic test_gpio_in();
        int lat, ac;
        logic f;
        logic [31:0] d;
        gpio_in = 8'h3C;
        repeat (2) begin @(posedge clk); #1; end
        bus_access(1'b1, 1'b0, BASE + 32'h0C, '0, lat, f, d, ac);
        checks++;
        if (d !== 32'h0000_003C || f !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gpio_in: got %h expected 0000003c", d);
        end
    endtask

    task automatic test_random();
        int lat, ac, el, sel, mode, bad;
        logic f, ef, r, w;
        logic [31:0] d, ed, a, v;
        gpio_in = 8'($urandom);
        repeat (3) begin @(posedge clk); #1; end
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)
                a = BASE + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            else if (sel < 8)
                a = BASE + 32'($urandom_range(0, 63));
            else
                a = $urandom;
            mode = $urandom_range(0, 9);
            r = (mode == 0) || (mode >= 6);
            w = (mode == 0) || (mode >= 2 && mode <= 5);
            v = $urandom;
            bus_access(r, w, a, v, lat, f, d, ac);
            model_access(r, w, a, v, ac, ef, ed, el);
            bad = (lat !== el) || (f !== ef) || (d !== ed);
            checks++;
            if (bad != 0) begin
                errors++;
                $display("[TB] FAIL random_%0d rd=%b wr=%b addr=%h: got lat=%0d fault=%b data=%h expected lat=%0d fault=%b data=%h",
                         i, r, w, a, lat, f, d, el, ef, ed);
            end
        end
        checks++;
        if (gpio_out !== model_gpio) begin
            errors++;
            $display("[TB] FAIL random_gpio_out: got %h expected %h", gpio_out, model_gpio);
        end
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        logic [31:0] v, d2;
        v = $urandom;
        eio_req = 1'b1; eio_rd = 1'b0; eio_wr = 1'b1;
        eio_addr = BASE + 32'h04; eio_wdata = v;
        n1 = -1;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk); #1;
            if (eio_ack === 1'b1) begin n1 = i; break; end
        end
        eio_rd = 1'b1; eio_wr = 1'b0;
        n2 = -1;
        d2 = '0;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk); #1;
            if (eio_ack === 1'b1) begin n2 = i; d2 = eio_data; break; end
        end
        eio_req = 1'b0; eio_rd = 1'b0;
        @(posedge clk); #1;
        model_scratch = v;
        checks++;
        if (n1 !== 1 + WAIT || n2 !== 2 + WAIT) begin
            errors++;
            $display("[TB] FAIL b2b_timing: got first=%0d second=%0d expected %0d %0d", n1, n2, 1 + WAIT, 2 + WAIT);
        end
        checks++;
        if (d2 !== v) begin
            errors++;
            $display("[TB] FAIL b2b_data: got %h expected %h", d2, v);
        end
    endtask

    task automatic test_reset_mid();
        int lat, ac, seen;
        logic f;
        logic [31:0] d;
        apply_reset();
        eio_req = 1'b1; eio_rd = 1'b0; eio_wr = 1'b1;
        eio_addr = BASE + 32'h04; eio_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        eio_req = 1'b0; eio_wr = 1'b0;
        @(posedge clk); #1;
        rst_edge = cyc;
        rst = 1'b0;
        seen = (eio_ack !== 1'b0) ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (eio_ack !== 1'b0) seen = 1;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_ack: got ack after reset expected none");
        end
        bus_access(1'b1, 1'b0, BASE + 32'h04, '0, lat, f, d, ac);
        checks++;
        if (d !== 32'd0 || lat !== 1 + WAIT) begin
            errors++;
            $display("[TB] FAIL reset_mid_scratch: got data=%h lat=%0d expected 00000000 %0d", d, lat, 1 + WAIT);
        end
    endtask

    initial begin
        test_reset();
        test_id_latency();
        test_scratch_gpio();
        test_faults();
        test_timer();
        test_gpio_in();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
